// File: rtl/data_sram_responder.sv
// ---------------------------------------------------------------------------
// data_sram_responder
//
// Slave end of the data_sram interface driven by the pipeline's memory
// stage.  Provides a word-organised data RAM with per-byte write enables,
// a free-running 32-bit timer register and a 16-bit LED register.  Any
// access that hits none of these is dropped and flagged on err_unmapped.
//
// Ports
//   clk             : clock, all state updates on the rising edge
//   reset           : asynchronous, active-high reset
//   data_sram_en    : access request this cycle
//   data_sram_wen   : byte write enables (lane i = bits [8i+7:8i]); 0 = read
//   data_sram_addr  : byte address, bits [1:0] ignored for decode
//   data_sram_wdata : write data, already lane-aligned by the initiator
//   data_sram_rdata : registered read data, valid the cycle after en
//   led             : LED register contents
//   err_unmapped    : registered one-cycle pulse for an unmapped access
//
// Handshake: data_sram_en acts as a valid with an implicit, permanently
// asserted ready.  Every cycle with en=1 is one complete transaction that
// is accepted at the next rising edge; there is no stall and no
// backpressure.  Its result appears on data_sram_rdata/err_unmapped right
// after that edge and data_sram_rdata is held while en=0.
// ---------------------------------------------------------------------------
module data_sram_responder #(
  parameter int unsigned DEPTH_LOG2 = 14,
  parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
  parameter logic [31:0] TIMER_ADDR = 32'hbfaf_e000,
  parameter logic [31:0] LED_ADDR   = 32'hbfaf_f000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic        err_unmapped
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  // Clears the in-window offset bits so the remainder can be compared with
  // the (window-aligned) RAM base.
  localparam logic [31:0] RAM_MASK = ~((32'd4 << DEPTH_LOG2) - 32'd1);

  // Substitute the enabled byte lanes of new_word into old_word.
  function automatic logic [31:0] merge_lanes(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  lane_en
  );
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) begin
        result[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return result;
  endfunction

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  logic [31:0]           mem [0:DEPTH-1];
  logic [31:0]           timer_q;
  logic [15:0]           led_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic                  ram_hit;
  logic                  timer_hit;
  logic                  led_hit;
  logic                  unmapped_hit;
  logic [DEPTH_LOG2-1:0] ram_index;
  logic                  wr_access;

  always_comb begin
    ram_hit      = 1'b0;
    timer_hit    = 1'b0;
    led_hit      = 1'b0;
    unmapped_hit = 1'b0;
    // RAM is checked first so that a mis-parameterised overlap still yields
    // exactly one target per access.
    if ((data_sram_addr & RAM_MASK) == RAM_BASE) begin
      ram_hit = 1'b1;
    end else if (data_sram_addr[31:2] == TIMER_ADDR[31:2]) begin
      timer_hit = 1'b1;
    end else if (data_sram_addr[31:2] == LED_ADDR[31:2]) begin
      led_hit = 1'b1;
    end else begin
      unmapped_hit = 1'b1;
    end
  end

  assign ram_index = data_sram_addr[DEPTH_LOG2+1:2];
  assign wr_access = data_sram_en && (data_sram_wen != 4'b0000);

  // -------------------------------------------------------------------------
  // Write-first merged values: the stored word with this cycle's enabled
  // write lanes substituted.  This is both what gets stored and what is
  // returned, so a store reads back its own post-write word.
  // -------------------------------------------------------------------------
  logic [31:0] ram_word;
  logic [31:0] ram_merged;
  logic [31:0] timer_merged;
  logic [31:0] led_merged;
  logic [31:0] read_value;

  assign ram_word     = mem[ram_index];
  assign ram_merged   = merge_lanes(ram_word, data_sram_wdata, data_sram_wen);
  assign timer_merged = merge_lanes(timer_q, data_sram_wdata, data_sram_wen);
  // Only lanes 0-1 exist in the LED register; upper lanes read as zero.
  assign led_merged   = merge_lanes({16'd0, led_q}, data_sram_wdata,
                                    {2'b00, data_sram_wen[1:0]});

  always_comb begin
    read_value = 32'd0;
    if (ram_hit) begin
      read_value = ram_merged;
    end else if (timer_hit) begin
      read_value = timer_merged;
    end else if (led_hit) begin
      read_value = led_merged;
    end
  end

  // -------------------------------------------------------------------------
  // RAM array: no reset so it maps onto block RAM.  The explicit reset
  // check keeps an access presented during reset from landing.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset && wr_access && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) begin
          mem[ram_index][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Timer: free-running, but a write replaces the increment for that cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= 32'd0;
    end else if (wr_access && timer_hit) begin
      timer_q <= timer_merged;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

  // -------------------------------------------------------------------------
  // LED register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= 16'd0;
    end else if (wr_access && led_hit) begin
      led_q <= led_merged[15:0];
    end
  end

  // -------------------------------------------------------------------------
  // Response registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      err_q <= data_sram_en && unmapped_hit;
      if (data_sram_en) begin
        rdata_q <= read_value;
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;
  assign err_unmapped    = err_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_data_sram_responder
//
// Directed vector table, hand-written reset/timer sequences and a random
// phase, all scored against a byte-addressed reference model of the
// memory map.
// ---------------------------------------------------------------------------
module tb_data_sram_responder;

  localparam logic [31:0] TIMER_A   = 32'hbfaf_e000;
  localparam logic [31:0] LED_A     = 32'hbfaf_f000;
  localparam longint      RAM_BYTES = 65536;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic [15:0] led;
  logic        err_unmapped;

  always #5 clk = ~clk;

  data_sram_responder dut (
    .clk            (clk),
    .reset          (reset),
    .data_sram_en   (en),
    .data_sram_wen  (wen),
    .data_sram_addr (addr),
    .data_sram_wdata(wdata),
    .data_sram_rdata(rdata),
    .led            (led),
    .err_unmapped   (err_unmapped)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mem_b [logic [31:0]];
  logic [31:0] m_timer;
  logic [15:0] m_led;
  logic [31:0] m_rdata;
  logic        m_err;

  function automatic int region(input logic [31:0] a);
    if ({32'd0, a} < RAM_BYTES) return 0;
    if ((a & ~32'd3) == TIMER_A) return 1;
    if ((a & ~32'd3) == LED_A) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_timer = 0;
    m_led   = 0;
    m_rdata = 0;
    m_err   = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic e, input logic [3:0] w,
                            input logic [31:0] a, input logic [31:0] d);
    logic [31:0] base, old, res;
    int          r;
    bit          timer_written;
    timer_written = 0;
    m_err = 0;
    if (e) begin
      base = a & ~32'd3;
      r    = region(a);
      old  = 32'd0;
      if (r == 0) for (int i = 0; i < 4; i++) old[8*i +: 8] = mem_b[base + i];
      if (r == 1) old = m_timer;
      if (r == 2) old = {16'd0, m_led};
      res = old;
      for (int i = 0; i < 4; i++) begin
        if (w[i] && (r == 0 || r == 1 || (r == 2 && i < 2))) res[8*i +: 8] = d[8*i +: 8];
      end
      if (r == 0) for (int i = 0; i < 4; i++) if (w[i]) mem_b[base + i] = d[8*i +: 8];
      if (r == 1 && w != 0) begin
        m_timer = res;
        timer_written = 1;
      end
      if (r == 2) m_led = res[15:0];
      if (r == 3) begin
        res   = 32'd0;
        m_err = 1;
      end
      m_rdata = res;
    end
    if (!timer_written) m_timer = m_timer + 1;
    exp_q.push_back(m_rdata);
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; returns at the next posedge+1 after checking.
  task automatic do_access(input logic e, input logic [3:0] w,
                           input logic [31:0] a, input logic [31:0] d,
                           input string name);
    logic [31:0] exp_r;
    en = e; wen = w; addr = a; wdata = d;
    @(posedge clk);
    model_step(e, w, a, d);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      exp_r = exp_q.pop_front();
      check({name, ".rdata"}, rdata, exp_r);
    end
    check({name, ".led"}, {16'd0, led}, {16'd0, m_led});
    check({name, ".err"}, {31'd0, err_unmapped}, {31'd0, m_err});
    en = 1'b0;
  endtask

  // Assert reset between edges while an access is presented.
  task automatic reset_mid(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = 1'b1; wen = w; addr = a; wdata = d;
    #3;
    reset = 1'b1;
    #1;
    check("mid_reset.rdata", rdata, 32'd0);
    check("mid_reset.led", {16'd0, led}, 32'd0);
    check("mid_reset.err", {31'd0, err_unmapped}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    en = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int idle_cnt;
    logic [31:0] ra;
    int r;

    // table (expected values worked out by hand)
    vecs.push_back('{1, 4'hf, 32'h100, 32'h1234_5678, 32'h1234_5678, 16'h0,    0});
    vecs.push_back('{1, 4'h0, 32'h100, 32'h0,         32'h1234_5678, 16'h0,    0});
    vecs.push_back('{1, 4'h4, 32'h102, 32'h00AB_0000, 32'h12AB_5678, 16'h0,    0});
    vecs.push_back('{1, 4'h0, 32'h100, 32'h0,         32'h12AB_5678, 16'h0,    0});
    vecs.push_back('{0, 4'h0, 32'h0,   32'h0,         32'h12AB_5678, 16'h0,    0});
    vecs.push_back('{1, 4'hf, LED_A,   32'hdead_beef, 32'h0000_beef, 16'hbeef, 0});
    vecs.push_back('{0, 4'h0, 32'h0,   32'h0,         32'h0000_beef, 16'hbeef, 0});
    vecs.push_back('{0, 4'h0, 32'h0,   32'h0,         32'h0000_beef, 16'hbeef, 0});
    vecs.push_back('{0, 4'h0, 32'h0,   32'h0,         32'h0000_beef, 16'hbeef, 0});
    vecs.push_back('{1, 4'h0, 32'h8000_0000, 32'h0,   32'h0,         16'hbeef, 1});
    vecs.push_back('{0, 4'h0, 32'h0,   32'h0,         32'h0,         16'hbeef, 0});
    vecs.push_back('{1, 4'hf, 32'h8000_0000, 32'hffff_ffff, 32'h0,   16'hbeef, 1});
    vecs.push_back('{1, 4'h0, 32'h8000_0000, 32'h0,   32'h0,         16'hbeef, 1});
    vecs.push_back('{1, 4'h0, 32'h100, 32'h0,         32'h12AB_5678, 16'hbeef, 0});
    vecs.push_back('{1, 4'hc, LED_A,   32'h1234_0000, 32'h0000_beef, 16'hbeef, 0});
    vecs.push_back('{1, 4'h1, LED_A,   32'h0000_00AA, 32'h0000_beaa, 16'hbeaa, 0});
    vecs.push_back('{1, 4'h0, 32'h0001_0000, 32'h0,   32'h0,         16'hbeaa, 1});
    vecs.push_back('{1, 4'hf, 32'h104, 32'ha5a5_a5a5, 32'ha5a5_a5a5, 16'hbeaa, 0});
    vecs.push_back('{1, 4'h8, 32'h104, 32'h3c00_0000, 32'h3ca5_a5a5, 16'hbeaa, 0});
    vecs.push_back('{1, 4'h0, 32'h104, 32'h0,         32'h3ca5_a5a5, 16'hbeaa, 0});
    vecs.push_back('{1, 4'hf, 32'hfffc, 32'h0bad_f00d, 32'h0bad_f00d, 16'hbeaa, 0});
    vecs.push_back('{1, 4'h0, 32'hfffe, 32'h0,        32'h0bad_f00d, 16'hbeaa, 0});

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset.rdata", rdata, 32'd0);
    check("reset.led", {16'd0, led}, 32'd0);
    check("reset.err", {31'd0, err_unmapped}, 32'd0);
    reset = 1'b0;
    model_reset();

    // table-driven phase
    for (int i = 0; i < vecs.size(); i++) begin
      do_access(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d.tbl_led", i), {16'd0, led}, {16'd0, vecs[i].exp_led});
      check($sformatf("vec%0d.tbl_err", i), {31'd0, err_unmapped}, {31'd0, vecs[i].exp_err});
    end

    // timer: fresh reset, idle 10 cycles, then read
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    idle_cnt = 0;
    repeat (10) begin
      do_access(0, 4'h0, 32'h0, 32'h0, "timer_idle");
      idle_cnt++;
    end
    do_access(1, 4'h0, TIMER_A, 32'h0, "timer_read");
    check("timer_after_idle", rdata, idle_cnt);

    // timer write then wrap
    do_access(1, 4'hf, TIMER_A, 32'hffff_fffe, "timer_write");
    check("timer_write_rdata", rdata, 32'hffff_fffe);
    do_access(0, 4'h0, 32'h0, 32'h0, "timer_gap");
    do_access(0, 4'h0, 32'h0, 32'h0, "timer_gap");
    do_access(1, 4'h0, TIMER_A, 32'h0, "timer_wrap");
    check("timer_wrap_value", rdata, 32'h0);

    // timer partial-lane write keeps unwritten lanes at pre-edge value
    do_access(1, 4'h2, TIMER_A + 32'd1, 32'h0000_7700, "timer_lane");

    // async reset mid-stream: rdata and led cleared, write suppressed
    do_access(1, 4'hf, LED_A, 32'h0000_1234, "pre_reset_led");
    do_access(1, 4'hf, 32'h200, 32'h1111_1111, "pre_reset_wr");
    reset_mid(4'hf, 32'h200, 32'h2222_2222);
    do_access(1, 4'h0, 32'h200, 32'h0, "post_reset_rd");
    check("post_reset_keeps_old", rdata, 32'h1111_1111);

    // async reset right after an unmapped access clears err_unmapped
    do_access(1, 4'h0, 32'h8000_0010, 32'h0, "pre_reset_unmapped");
    reset_mid(4'hf, 32'h200, 32'h3333_3333);
    do_access(1, 4'h0, 32'h200, 32'h0, "post_reset_rd2");

    // random phase: initialise a small RAM window, then mix everything
    for (int i = 0; i < 32; i++) begin
      do_access(1, 4'hf, i * 4, $urandom(), "rand_init");
    end
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 11);
      case (r)
        0, 1, 2, 3, 4, 5: ra = {$urandom_range(0, 31), 2'b00} | 32'($urandom_range(0, 3));
        6:                ra = TIMER_A | 32'($urandom_range(0, 3));
        7:                ra = LED_A | 32'($urandom_range(0, 3));
        8:                ra = 32'h8000_0000 | {$urandom_range(0, 16'hffff), 2'b00};
        9:                ra = 32'h0001_0000 + {$urandom_range(0, 255), 2'b00};
        default:          ra = 32'h0;
      endcase
      if (r >= 10) begin
        do_access(0, 4'($urandom()), ra, $urandom(), "rand_idle");
      end else begin
        do_access(1, ($urandom_range(0, 1) != 0) ? 4'($urandom()) : 4'h0, ra, $urandom(), "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Slave end of the data_sram interface driven by the pipeline's memory stage.
- Accepts en/wen/addr/wdata.
- Holds a word-organised data RAM with per-byte write enables.
- Returns read data with a registered one-cycle latency.
- Also decodes two MMIO registers: a free-running timer and an LED register.
- Unmapped accesses are flagged.
- Sits between the CPU core and the board/testbench as the data-side memory.

Parameters:
- DEPTH_LOG2, 14, log2 of RAM depth in 32-bit words (64 KiB default).
- RAM_BASE, 32'h0000_0000, byte base address of RAM window; aligned to 4*2^DEPTH_LOG2.
- TIMER_ADDR, 32'hbfaf_e000, word address of timer register.
- LED_ADDR, 32'hbfaf_f000, word address of LED register.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_sram_en  input  1  access request this cycle.
- data_sram_wen  input  4  byte write enables; lane i covers bits [8i+7:8i]; 0 means read.
- data_sram_addr  input  32  byte address; bits [1:0] ignored for decode.
- data_sram_wdata  input  32  write data, already lane-aligned by initiator.
- data_sram_rdata  output  32  registered read data.
- led  output  16  LED register contents.
- err_unmapped  output  1  one-cycle pulse, registered, for an access to an unmapped address.

Behaviour:
- Reset (async assert) forces data_sram_rdata=0, led=0, err_unmapped=0, and timer=0.
  - RAM contents are not reset.
  - An access presented while reset is high has no effect.
- Decode uses word address addr[31:2]; exactly one of the following holds per access:
  - ram_hit: (addr & ~(4*2^DEPTH_LOG2-1)) == RAM_BASE; index = addr[DEPTH_LOG2+1:2].
  - timer_hit: addr[31:2]==TIMER_ADDR[31:2].
  - led_hit: addr[31:2]==LED_ADDR[31:2].
  - unmapped: none of the above.
- Write, at the edge where en=1 and wen!=0, updates only the enabled lanes:
  - RAM: enabled lanes of the word at index.
  - Timer: enabled lanes of timer.
  - LED: lanes 0-1 update led[15:0]; lanes 2-3 are ignored.
  - Unmapped: dropped.
- Read data, at every edge with en=1, data_sram_rdata <= merged value:
  - Merged value = current stored word with this cycle's enabled write lanes substituted (write-first).
  - A store returns its post-write word.
  - Latency is 1 cycle: data is valid the cycle after en.
  - With en=0, data_sram_rdata holds its previous value.
- Read sources:
  - RAM word.
  - Timer value before this edge's increment, with write lanes merged.
  - {16'd0, led}, with write lanes 0-1 merged.
  - Unmapped returns 32'd0.
- Timer:
  - Increments by 1 every cycle out of reset; wraps 32'hffff_ffff -> 0.
  - In a cycle where it is written, it takes the written lanes and does not increment; unwritten lanes keep their pre-edge value.
  - It resumes incrementing next cycle.
- err_unmapped:
  - Is set to 1 at the edge after an en=1 unmapped access, read or write.
  - Otherwise it is 0; back-to-back unmapped accesses hold it at 1.
- Back-to-back accesses to the same RAM word, one per cycle, each observe all prior writes; no stall or hazard exists.
- No backpressure: every en=1 cycle is accepted.

Test Plan:
- Full-word write then read: en=1, wen=4'hf, addr=0x100, wdata=0x12345678; next cycle en=1, wen=0, addr=0x100 -> rdata=0x12345678 one cycle after the read.
- Byte-lane write: after the above, wen=4'b0100, addr=0x102, wdata=0x00AB0000; then read 0x100 -> 0x12AB5678. The store itself returns 0x12AB5678 on rdata.
- Timer:
  - Release reset, idle 10 cycles, read TIMER_ADDR -> rdata=10 (±0 by construction, checked against a bench counter).
  - Write wen=4'hf, wdata=0xffff_fffe; read 2 cycles later -> 0x0000_0000 (wrap).
- LED and hold: write LED_ADDR wen=4'hf, wdata=0xdead_beef -> led=0xbeef, rdata=0x0000beef. Hold en=0 for 3 cycles -> rdata is unchanged.
- Unmapped: read addr=0x8000_0000 -> rdata=0 and err_unmapped=1 for exactly one cycle; a write there leaves RAM, led, and timer unchanged.
- Async reset mid-stream: assert reset between edges during a write burst -> rdata, led, err_unmapped become 0 immediately. The write presented during reset is not performed (readback after reset shows the prior value).
